// File: rtl/color_conv_tile_sequencer.sv
// Tile sequencer for the colour converter. It walks the N tiles of one job, starts the RGB source
// and YCbCr sink streamers together for each tile, and pulses done once the last tile drains.
module color_conv_tile_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TILE_CNT_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic [TILE_CNT_WIDTH-1:0] n_tiles_i,
  input  logic [ADDR_WIDTH-1:0]     rgb_base_i,
  input  logic [ADDR_WIDTH-1:0]     ycbcr_base_i,
  input  logic [ADDR_WIDTH-1:0]     rgb_tile_stride_i,
  input  logic [ADDR_WIDTH-1:0]     ycbcr_tile_stride_i,
  input  logic                      src_ready_start_i,
  input  logic                      snk_ready_start_i,
  input  logic                      src_done_i,
  input  logic                      snk_done_i,
  output logic                      src_req_start_o,
  output logic                      snk_req_start_o,
  output logic [ADDR_WIDTH-1:0]     rgb_base_addr_o,
  output logic [ADDR_WIDTH-1:0]     ycbcr_base_addr_o,
  output logic [TILE_CNT_WIDTH-1:0] tile_idx_o,
  output logic                      busy_o,
  output logic                      done_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StRun, StDone} state_e;

  state_e                    state_q, state_d;
  logic [TILE_CNT_WIDTH-1:0] n_tiles_q, n_tiles_d;
  logic [TILE_CNT_WIDTH-1:0] tile_idx_q, tile_idx_d;
  logic [ADDR_WIDTH-1:0]     rgb_stride_q, rgb_stride_d;
  logic [ADDR_WIDTH-1:0]     ycbcr_stride_q, ycbcr_stride_d;
  logic [ADDR_WIDTH-1:0]     rgb_addr_q, rgb_addr_d;
  logic [ADDR_WIDTH-1:0]     ycbcr_addr_q, ycbcr_addr_d;
  logic                      src_seen_q, src_seen_d;
  logic                      snk_seen_q, snk_seen_d;
  logic                      issue_fire, tile_done, last_tile;

  // Both streamers are started in the same cycle, only once both can take the request.
  assign issue_fire = (state_q == StIssue) & src_ready_start_i & snk_ready_start_i;
  assign tile_done  = (state_q == StRun) & (src_seen_q | src_done_i) & (snk_seen_q | snk_done_i);
  assign last_tile  = (tile_idx_q == n_tiles_q - TILE_CNT_WIDTH'(1));

  always_comb begin
    state_d        = state_q;
    n_tiles_d      = n_tiles_q;
    tile_idx_d     = tile_idx_q;
    rgb_stride_d   = rgb_stride_q;
    ycbcr_stride_d = ycbcr_stride_q;
    rgb_addr_d     = rgb_addr_q;
    ycbcr_addr_d   = ycbcr_addr_q;
    src_seen_d     = src_seen_q;
    snk_seen_d     = snk_seen_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          n_tiles_d      = n_tiles_i;
          rgb_stride_d   = rgb_tile_stride_i;
          ycbcr_stride_d = ycbcr_tile_stride_i;
          rgb_addr_d     = rgb_base_i;
          ycbcr_addr_d   = ycbcr_base_i;
          tile_idx_d     = '0;
          state_d        = (n_tiles_i == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (issue_fire) begin
          src_seen_d = 1'b0;
          snk_seen_d = 1'b0;
          state_d    = StRun;
        end
      end
      StRun: begin
        src_seen_d = src_seen_q | src_done_i;
        snk_seen_d = snk_seen_q | snk_done_i;
        if (tile_done) begin
          if (last_tile) begin
            state_d = StDone;
          end else begin
            tile_idx_d   = tile_idx_q + TILE_CNT_WIDTH'(1);
            rgb_addr_d   = rgb_addr_q + rgb_stride_q;
            ycbcr_addr_d = ycbcr_addr_q + ycbcr_stride_q;
            state_d      = StIssue;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Soft clear aborts the job silently; address registers are left as they were.
    if (clear_i) begin
      state_d    = StIdle;
      tile_idx_d = '0;
      src_seen_d = 1'b0;
      snk_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      n_tiles_q      <= '0;
      tile_idx_q     <= '0;
      rgb_stride_q   <= '0;
      ycbcr_stride_q <= '0;
      rgb_addr_q     <= '0;
      ycbcr_addr_q   <= '0;
      src_seen_q     <= 1'b0;
      snk_seen_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_tiles_q      <= n_tiles_d;
      tile_idx_q     <= tile_idx_d;
      rgb_stride_q   <= rgb_stride_d;
      ycbcr_stride_q <= ycbcr_stride_d;
      rgb_addr_q     <= rgb_addr_d;
      ycbcr_addr_q   <= ycbcr_addr_d;
      src_seen_q     <= src_seen_d;
      snk_seen_q     <= snk_seen_d;
    end
  end

  assign src_req_start_o   = issue_fire;
  assign snk_req_start_o   = issue_fire;
  assign rgb_base_addr_o   = rgb_addr_q;
  assign ycbcr_base_addr_o = ycbcr_addr_q;
  assign tile_idx_o        = tile_idx_q;
  assign busy_o            = (state_q != StIdle);
  assign done_o            = (state_q == StDone);

endmodule
